// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: recovers hex digits from a multiplexed 4-digit, 7-segment
// display bus. Each anode/cathode combination must be stable for SETTLE_CYCLES
// cycles before the active digit's segment pattern is decoded.
//
// Ports:
//   ClkPort    - system clock (100 MHz)
//   Reset      - asynchronous, active-high reset
//   An[3:0]    - scanned anodes, active-low, bit i selects digit i
//   Cath[7:0]  - cathodes {a,b,c,d,e,f,g,dp}, active-low
//   Digits     - recovered nibbles, digit i at [4i+3:4i]
//   DigitValid - bit i set when nibble i holds a valid decode
//   FrameDone  - one-cycle pulse when all four digits were sampled
//   CodeErr    - one-cycle pulse on a bad segment pattern or multi-low anode
//   ErrCount   - saturating count of CodeErr pulses
//   DpOut      - captured decimal points (only with SSD_DP_CAPTURE_EN)
//
// Build option: define SSD_DP_CAPTURE_EN to add the DpOut port.
module ssd_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic [3:0]  An,
    input  logic [7:0]  Cath,
    output logic [15:0] Digits,
    output logic [3:0]  DigitValid,
    output logic        FrameDone,
    output logic        CodeErr,
    output logic [7:0]  ErrCount
`ifdef SSD_DP_CAPTURE_EN
    ,
    output logic [3:0]  DpOut
`endif
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef SSD_DP_CAPTURE_EN
    localparam logic [7:0] CATH_MASK = 8'hFF;
`else
    localparam logic [7:0] CATH_MASK = 8'hFE;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       an_s1, an_s2, an_prev;
    logic [7:0]       cath_s1, cath_s2, cath_prev;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       seen_q;

    logic       an_idle_c, an_one_c, an_multi_c;
    logic [1:0] an_idx_c;
    logic       an_chg_c, cath_chg_c;
    logic       cnt_clr_c, cnt_inc_c, idx_load_c, sample_c, err_c;
    logic [4:0] dec_c;
    logic [3:0] seen_set_c;
    logic       err_any_c;

    // Active-low abcdefg pattern -> {valid, nibble}
    function automatic logic [4:0] decode7(input logic [6:0] seg);
        case (seg)
            7'b0000001: decode7 = {1'b1, 4'h0};
            7'b1001111: decode7 = {1'b1, 4'h1};
            7'b0010010: decode7 = {1'b1, 4'h2};
            7'b0000110: decode7 = {1'b1, 4'h3};
            7'b1001100: decode7 = {1'b1, 4'h4};
            7'b0100100: decode7 = {1'b1, 4'h5};
            7'b0100000: decode7 = {1'b1, 4'h6};
            7'b0001111: decode7 = {1'b1, 4'h7};
            7'b0000000: decode7 = {1'b1, 4'h8};
            7'b0000100: decode7 = {1'b1, 4'h9};
            7'b0001000: decode7 = {1'b1, 4'hA};
            7'b1100000: decode7 = {1'b1, 4'hB};
            7'b0110001: decode7 = {1'b1, 4'hC};
            7'b1000010: decode7 = {1'b1, 4'hD};
            7'b0110000: decode7 = {1'b1, 4'hE};
            7'b0111000: decode7 = {1'b1, 4'hF};
            default:    decode7 = 5'b0_0000;
        endcase
    endfunction

    // Anode classification
    always_comb begin
        an_one_c = 1'b1;
        an_idx_c = 2'd0;
        case (an_s2)
            4'b1110: an_idx_c = 2'd0;
            4'b1101: an_idx_c = 2'd1;
            4'b1011: an_idx_c = 2'd2;
            4'b0111: an_idx_c = 2'd3;
            default: an_one_c = 1'b0;
        endcase
    end

    assign an_idle_c  = (an_s2 == 4'b1111);
    assign an_multi_c = !an_idle_c && !an_one_c;
    assign an_chg_c   = (an_s2 != an_prev);
    assign cath_chg_c = |((cath_s2 ^ cath_prev) & CATH_MASK);
    assign dec_c      = decode7(cath_s2[7:1]);
    assign seen_set_c = seen_q | (4'b0001 << idx_q);
    assign err_any_c  = err_c || (sample_c && !dec_c[4]);

    // State register
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and control
    always_comb begin
        state_d    = state_q;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        idx_load_c = 1'b0;
        sample_c   = 1'b0;
        err_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (an_one_c) begin
                    state_d    = ST_SETTLE;
                    cnt_clr_c  = 1'b1;
                    idx_load_c = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (an_idle_c) begin
                    state_d = ST_IDLE;
                end else if (an_multi_c) begin
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (an_chg_c || cath_chg_c) begin
                    // Restart the stability window; anode may now name another digit
                    cnt_clr_c  = 1'b1;
                    idx_load_c = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            ST_SAMPLE: begin
                sample_c = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                // Only an anode change leaves HOLD; cathode changes are ignored
                if (an_chg_c) begin
                    if (an_one_c) begin
                        state_d    = ST_SETTLE;
                        cnt_clr_c  = 1'b1;
                        idx_load_c = 1'b1;
                    end else if (an_multi_c) begin
                        err_c   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Synchronizers, settle counter and captured outputs
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            an_s1      <= 4'hF;
            an_s2      <= 4'hF;
            an_prev    <= 4'hF;
            cath_s1    <= 8'hFF;
            cath_s2    <= 8'hFF;
            cath_prev  <= 8'hFF;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            seen_q     <= 4'b0000;
            Digits     <= 16'h0000;
            DigitValid <= 4'b0000;
            FrameDone  <= 1'b0;
            CodeErr    <= 1'b0;
            ErrCount   <= 8'd0;
`ifdef SSD_DP_CAPTURE_EN
            DpOut      <= 4'b0000;
`endif
        end else begin
            an_s1     <= An;
            an_s2     <= an_s1;
            an_prev   <= an_s2;
            cath_s1   <= Cath;
            cath_s2   <= cath_s1;
            cath_prev <= cath_s2;

            if (cnt_clr_c)      cnt_q <= '0;
            else if (cnt_inc_c) cnt_q <= cnt_q + CNT_W'(1);

            if (idx_load_c) idx_q <= an_idx_c;

            FrameDone <= sample_c && (seen_set_c == 4'b1111);
            CodeErr   <= err_any_c;
            if (err_any_c && (ErrCount != 8'hFF)) ErrCount <= ErrCount + 8'd1;

            if (sample_c) begin
                if (dec_c[4]) begin
                    Digits[{idx_q, 2'b00} +: 4] <= dec_c[3:0];
                    DigitValid[idx_q]           <= 1'b1;
                end else begin
                    DigitValid[idx_q] <= 1'b0;
                end
                // A completed frame clears seen as FrameDone rises
                seen_q <= (seen_set_c == 4'b1111) ? 4'b0000 : seen_set_c;
`ifdef SSD_DP_CAPTURE_EN
                DpOut[idx_q] <= ~cath_s2[0];
`endif
            end
        end
    end

endmodule
